// File: rtl/booth_mul_sched_if.sv
// Request/result bundle for booth_mul_sched.
//   req_valid[1:0]  requester valid, bit i = requester i
//   req_ready[1:0]  per-requester accept (one-hot or zero)
//   req_a0/req_b0   requester 0 multiplier / multiplicand
//   req_a1/req_b1   requester 1 multiplier / multiplicand
//   out_valid/out_ready  result handshake
//   out_product     unsigned product a*b
//   out_id          requester index of the result
//   busy            an operation is in flight (RUN or DONE)
// master: requester/consumer side; slave: the multiplier.
interface booth_mul_sched_if #(
  parameter int unsigned WIDTH = 16
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [WIDTH-1:0]   req_a0;
  logic [WIDTH-1:0]   req_b0;
  logic [WIDTH-1:0]   req_a1;
  logic [WIDTH-1:0]   req_b1;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic               out_id;
  logic               busy;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, out_ready,
    input  req_ready, out_valid, out_product, out_id, busy
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, out_ready,
    output req_ready, out_valid, out_product, out_id, busy
  );
endinterface

// File: rtl/booth_mul_sched.sv
// Shared sequential radix-2 Booth multiplier with a two-port round-robin
// front end. One Booth substep per clock; WIDTH+1 substeps per operation.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  booth_mul_sched_if slave modport (requests, result, busy)
// WIDTH must match the WIDTH of the connected interface.
module booth_mul_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  booth_mul_sched_if.slave  bus
);
  localparam int unsigned STEPS = WIDTH + 1;
  localparam int unsigned SW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH:0]  acc, q, m;
  logic            q_m1;
  logic [SW-1:0]   step;
  logic            id, last_id;
  logic            grant, accept, last_step;
  logic [WIDTH:0]  sum;

  // Round-robin: a lone requester wins; on a tie the one that did not win last.
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_id;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && bus.req_valid[grant];
    last_step = (step == SW'(STEPS - 1));
  end

  // Booth add/subtract; width is WIDTH+1 so the subtract carry is dropped.
  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = '0;
    bus.out_valid   = 1'b0;
    bus.out_product = '0;
    bus.out_id      = id;
    bus.busy        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid[grant]) bus.req_ready[grant] = 1'b1;
      end
      RUN: bus.busy = 1'b1;
      DONE: begin
        bus.busy        = 1'b1;
        bus.out_valid   = 1'b1;
        // Low 2*WIDTH bits of {acc, q}; the top two acc bits are always zero here.
        bus.out_product = {acc[WIDTH-2:0], q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      q_m1    <= 1'b0;
      step    <= '0;
      id      <= 1'b0;
      last_id <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc     <= '0;
            q       <= {1'b0, grant ? bus.req_a1 : bus.req_a0};
            m       <= {1'b0, grant ? bus.req_b1 : bus.req_b0};
            q_m1    <= 1'b0;
            step    <= '0;
            id      <= grant;
            last_id <= grant;
          end
        end
        RUN: begin
          // Arithmetic right shift of {sum, q, q_m1}.
          acc  <= {sum[WIDTH], sum[WIDTH:1]};
          q    <= {sum[0], q[WIDTH:1]};
          q_m1 <= q[0];
          step <= step + SW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/booth_mul_sched.md
# booth_mul_sched

Sequential, shared radix-2 Booth multiplier with a two-port round-robin front end. Two requesters submit unsigned WIDTH×WIDTH multiplies through valid/ready handshakes. The block runs one Booth substep per clock on a single internal datapath, then returns the 2·WIDTH-bit product tagged with the requester ID. It replaces the fully unrolled combinational multiplier wherever area matters more than latency.

## Interface
- WIDTH, 16, operand width; accumulator and Q registers are WIDTH+1 bits; STEPS = WIDTH+1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; at most one bit high per cycle.
- req_a0, req_b0  input  WIDTH  requester 0 multiplier and multiplicand.
- req_a1, req_b1  input  WIDTH  requester 1 multiplier and multiplicand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_product  output  2·WIDTH  unsigned product a·b.
- out_id  output  1  requester index of the result.
- busy  output  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Arbiter computes grant from req_valid and the pointer last_id.
  - If only one requester is valid, it wins.
  - If both are valid, the requester ≠ last_id wins.
  - req_ready[grant] = 1 only when that requester is valid.
- Accept edge (req_valid[g] & req_ready[g]):
  - acc ← 0.
  - Q ← {1'b0, a_g}.
  - M ← {1'b0, b_g}.
  - q_m1 ← 0.
  - step ← 0.
  - id ← g, last_id ← g.
  - Go to RUN.
- RUN, each edge performs one Booth substep:
  - Q[0],q_m1 = 01: acc ← acc + M.
  - Q[0],q_m1 = 10: acc ← acc − M, using a (WIDTH+1)-bit two's-complement add; carry out is discarded.
  - Q[0],q_m1 = 00 or 11: acc is unchanged.
  - Then apply an arithmetic right shift of {acc', Q, q_m1} by one bit: the acc sign bit is replicated, the acc LSB moves into Q MSB, and Q[0] moves into q_m1.
  - step increments by one.
  - On the edge where step = STEPS−1, go to DONE.
- DONE:
  - out_valid = 1.
  - out_product = low 2·WIDTH bits of {acc, Q}.
  - out_id = id.
  - When out_valid & out_ready, go to IDLE.
  - Outputs hold stable while out_ready is low.
- Requester rules:
  - req_valid must stay high, with operands stable, until accepted.
  - Operands are sampled only on the accept edge; later changes have no effect.
- req_ready is 0 in RUN and DONE, so there is no new accept while an operation is in flight.
- Reset, at any time including mid-RUN or DONE:
  - state = IDLE, and the in-flight operation is discarded.
  - last_id = 1, so requester 0 wins the first tie.
  - acc, Q, M, q_m1, step, and id are all 0.
- Reset values of outputs: req_ready = 0 (pure function of state and req_valid, so it is 0 when no requester is valid), out_valid = 0, out_product = 0, out_id = 0, busy = 0.

## Timing
- Accept at edge T.
- Substeps occur at edges T+1 … T+STEPS; T+17 for WIDTH=16.
- out_valid rises after edge T+STEPS.
- Latency from accept to out_valid is 17 cycles.
- If out_ready is high while out_valid is high, the handshake completes at edge T+STEPS+1 and the state returns to IDLE.
- The next accept is possible at edge T+STEPS+2.
- Minimum period is 19 cycles per operation.
- With both requesters continuously valid and out_ready = 1, grants alternate 0,1,0,1… with no starvation.
- req_ready is combinational from state, last_id, and req_valid.
- out_* and busy are driven from registered state only; there is no combinational path from out_ready to out_valid.

## Test plan
- Basic multiply:
  - Stimulus: requester 0 only, a=3, b=5; out_ready=1.
  - Response: out_valid 17 cycles after accept, with out_product=0x0000000F and out_id=0.
- Corner operands:
  - Stimulus: a=0xFFFF, b=0xFFFF.
  - Response: out_product=0xFFFE0001.
  - Stimulus: a=0x8000, b=0x0002.
  - Response: out_product=0x00010000.
  - Stimulus: a=0, b=0x1234.
  - Response: out_product=0.
- Arbitration:
  - Stimulus: both requesters valid from reset, (a0,b0)=(7,9) and (a1,b1)=(100,200), out_ready=1.
  - Response: results arrive in the order id 0 → 63, then id 1 → 20000, then id 0 again; each result is 19 cycles apart.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid.
  - Response: out_valid, out_product, and out_id stay constant; req_ready=0 throughout; one transfer occurs when out_ready rises.
- Operand isolation:
  - Stimulus: change req_a0 and req_b0 on the cycle after accept.
  - Response: the product still reflects the accepted values.
- Reset mid-RUN:
  - Stimulus: assert rst at substep 8.
  - Response: all outputs 0 immediately (asynchronously), no result is produced, and after release requester 0 wins the first tie.
